// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: base opcodes, instruction format classes and the canonical NOP.
// Used by the immediate encoder and its range checker.
package riscv_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [31:0] NOP_WORD = 32'h00000013;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } fmt_e;

    function automatic fmt_e fmt_of(input logic [6:0] op);
        fmt_e f;
        case (op)
            OP_R:                     f = FMT_R;
            OP_I, OP_LOAD, OP_JALR:   f = FMT_I;
            OP_S:                     f = FMT_S;
            OP_B:                     f = FMT_B;
            OP_LUI, OP_AUIPC:         f = FMT_U;
            OP_JAL:                   f = FMT_J;
            default:                  f = FMT_BAD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imm_range_check.sv
// Decides whether a 32-bit immediate fits the field of the given instruction format.
// A field fits when every bit above its sign bit equals that sign bit.
module imm_range_check
    import riscv_pkg::*;
(
    input  fmt_e              fmt,
    input  logic signed [31:0] imm,
    output logic              err
);

    always_comb begin
        err = 1'b0;
        case (fmt)
            FMT_R:   err = 1'b0;
            FMT_I,
            FMT_S:   err = (imm[31:11] != {21{imm[11]}});
            FMT_B:   err = (imm[31:12] != {20{imm[12]}}) || imm[0];
            FMT_U:   err = (imm[11:0] != 12'd0);
            FMT_J:   err = (imm[31:20] != {12{imm[20]}}) || imm[0];
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// RV32I instruction assembler: range-checks the immediate (stage 1), then scatters fields
// into the instruction word (stage 2) behind a valid/ready pipeline with saturating statistics.
module imm_encoder
    import riscv_pkg::*;
#(
    parameter int unsigned CNT_W    = 16,
    parameter logic [31:0] NOP_WORD = riscv_pkg::NOP_WORD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    function automatic logic [31:0] assemble(
        input fmt_e               f,
        input logic [6:0]         op,
        input logic [4:0]         rd,
        input logic [4:0]         rs1,
        input logic [4:0]         rs2,
        input logic [2:0]         f3,
        input logic [6:0]         f7,
        input logic signed [31:0] imm
    );
        logic [31:0] w;
        case (f)
            FMT_R:   w = {f7, rs2, rs1, f3, rd, op};
            FMT_I:   w = {imm[11:0], rs1, f3, rd, op};
            FMT_S:   w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            FMT_B:   w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            FMT_U:   w = {imm[31:12], rd, op};
            FMT_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default: w = NOP_WORD;
        endcase
        return w;
    endfunction

    logic adv_p1, adv_p2;
    logic vld_p1, vld_p2;

    // Stage 0 -> 1: classify and range-check the incoming fields
    fmt_e fmt_p0;
    logic err_p0;

    assign fmt_p0 = fmt_of(in_opcode);

    imm_range_check u_range (
        .fmt (fmt_p0),
        .imm (in_imm),
        .err (err_p0)
    );

    assign adv_p2   = !vld_p2 || out_ready;
    assign adv_p1   = !vld_p1 || adv_p2;
    assign in_ready = adv_p1;

    fmt_e               fmt_p1;
    logic               err_p1;
    logic [6:0]         op_p1;
    logic [4:0]         rd_p1, rs1_p1, rs2_p1;
    logic [2:0]         f3_p1;
    logic [6:0]         f7_p1;
    logic signed [31:0] imm_p1;

    always_ff @(posedge clk) begin
        if (adv_p1 && in_valid) begin
            fmt_p1 <= fmt_p0;
            err_p1 <= err_p0;
            op_p1  <= in_opcode;
            rd_p1  <= in_rd;
            rs1_p1 <= in_rs1;
            rs2_p1 <= in_rs2;
            f3_p1  <= in_funct3;
            f7_p1  <= in_funct7;
            imm_p1 <= in_imm;
        end
    end

    // Stage 1 -> 2: assemble the word; flagged words become NOPs
    logic [31:0] instr_p1;

    assign instr_p1 = err_p1 ? NOP_WORD
                             : assemble(fmt_p1, op_p1, rd_p1, rs1_p1, rs2_p1, f3_p1, f7_p1, imm_p1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            out_instr <= 32'd0;
            out_err   <= 1'b0;
            enc_count <= '0;
            err_count <= '0;
        end else begin
            if (adv_p1) begin
                vld_p1 <= in_valid;
            end
            if (adv_p2) begin
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    out_instr <= instr_p1;
                    out_err   <= err_p1;
                end
            end
            if (vld_p2 && out_ready) begin
                enc_count <= sat_inc(enc_count);
                if (out_err) begin
                    err_count <= sat_inc(err_count);
                end
            end
        end
    end

    assign out_valid = vld_p2;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: single-word encodings, range errors, backpressure,
// mid-stream reset and counter saturation on a narrow-counter instance.
module tb_imm_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_ready;

    logic        in_ready, out_valid, out_err;
    logic [31:0] out_instr;
    logic [15:0] enc_count, err_count;

    logic        s_in_ready, s_out_valid, s_out_err;
    logic [31:0] s_out_instr;
    logic [1:0]  s_enc_count, s_err_count;

    int checks = 0;
    int errors = 0;
    int exp_enc = 0;
    int exp_err = 0;

    imm_encoder u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .enc_count (enc_count),
        .err_count (err_count)
    );

    imm_encoder #(.CNT_W(2)) u_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (s_in_ready),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (s_out_valid),
        .out_ready (out_ready),
        .out_instr (s_out_instr),
        .out_err   (s_out_err),
        .enc_count (s_enc_count),
        .err_count (s_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    // Called at a falling edge with an empty pipe and out_ready=1.
    task automatic send_one(input string tag, input logic [6:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] imm,
                            input logic [31:0] ei, input logic ee);
        in_valid  = 1'b1;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
        #1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_s_in_ready"}, 32'(s_in_ready), 32'd1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_latency"}, 32'(out_valid), 32'd0);
        @(posedge clk); @(negedge clk);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_instr"}, out_instr, ei);
        chk({tag, "_err"}, 32'(out_err), 32'(ee));
        chk({tag, "_s_instr"}, s_out_instr, ei);
        chk({tag, "_s_err"}, 32'(s_out_err), 32'(ee));
        @(posedge clk); @(negedge clk);
        exp_enc++;
        if (ee) exp_err++;
        chk({tag, "_drained"}, 32'(out_valid), 32'd0);
        chk({tag, "_enc_count"}, 32'(enc_count), 32'(exp_enc));
        chk({tag, "_err_count"}, 32'(err_count), 32'(exp_err));
        chk({tag, "_s_enc_count"}, 32'(s_enc_count), 32'(sat3(exp_enc)));
        chk({tag, "_s_err_count"}, 32'(s_err_count), 32'(sat3(exp_err)));
    endtask

    logic [31:0] exp_w [4];
    int sent, popped;
    logic acc;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_enc_count", 32'(enc_count), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        send_one("addi_m1",  7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0);
        send_one("sw",       7'b0100011, 5'd0, 5'd3, 5'd2, 3'b010, 7'd0, 32'd8,        32'h0021A423, 1'b0);
        send_one("lui",      7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345000, 32'h123452B7, 1'b0);
        send_one("jal_800",  7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h00000800, 32'h001000EF, 1'b0);
        send_one("jal_odd",  7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd3,        32'h00000013, 1'b1);
        send_one("addi_2048",7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048,     32'h00000013, 1'b1);
        send_one("addi_min", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFFF800, 32'h80000093, 1'b0);
        send_one("addi_max", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2047,     32'h7FF00093, 1'b0);
        send_one("beq_m4",   7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0);
        send_one("beq_4096", 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd4096,     32'h00000013, 1'b1);
        send_one("jal_min",  7'b1101111, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFF00000, 32'h8000006F, 1'b0);
        send_one("add",      7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'hDEADBEEF, 32'h002081B3, 1'b0);
        send_one("bad_op",   7'b1111111, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0,        32'h00000013, 1'b1);
        send_one("auipc_lo", 7'b0010111, 5'd4, 5'd0, 5'd0, 3'b000, 7'd0, 32'h00001001, 32'h00000013, 1'b1);

        // Fill both stages under backpressure, then reset
        out_ready = 1'b0;
        in_valid = 1'b1; in_opcode = 7'b0010011; in_rd = 5'd1; in_rs1 = 5'd0; in_imm = 32'd5;
        @(posedge clk); @(negedge clk);
        in_rd = 5'd2; in_imm = 32'd6;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("full_out_valid", 32'(out_valid), 32'd1);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_enc_count", 32'(enc_count), 32'd0);
        chk("mid_rst_err_count", 32'(err_count), 32'd0);
        chk("mid_rst_out_instr", out_instr, 32'd0);
        chk("mid_rst_s_enc_count", 32'(s_enc_count), 32'd0);
        rst_n = 1'b1; out_ready = 1'b1;
        exp_enc = 0; exp_err = 0;
        #1;
        chk("mid_rel_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); @(negedge clk);
        chk("mid_discard", 32'(out_valid), 32'd0);
        send_one("post_rst", 7'b0100011, 5'd0, 5'd3, 5'd2, 3'b010, 7'd0, 32'd8, 32'h0021A423, 1'b0);

        // Re-clear counters, then stream four words through a 3-cycle stall
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        exp_enc = 0; exp_err = 0;
        exp_w[0] = 32'h00100093; exp_w[1] = 32'h00200113;
        exp_w[2] = 32'h00300193; exp_w[3] = 32'h00400213;
        sent = 0; popped = 0;
        for (int c = 0; c < 12; c++) begin
            out_ready = !(c >= 1 && c <= 3);
            if (sent < 4) begin
                in_valid = 1'b1; in_opcode = 7'b0010011; in_rs1 = 5'd0; in_funct3 = 3'b000;
                in_rd = 5'(sent + 1); in_imm = 32'(sent + 1);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c == 2) chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                chk($sformatf("bp_word%0d", popped), out_instr, exp_w[popped & 3]);
                chk($sformatf("bp_err%0d", popped), 32'(out_err), 32'd0);
                popped++;
            end
            @(posedge clk); @(negedge clk);
            if (acc) sent++;
        end
        out_ready = 1'b1;
        exp_enc = 4;
        chk("bp_popped", 32'(popped), 32'd4);
        chk("bp_enc_count", 32'(enc_count), 32'd4);
        chk("bp_err_count", 32'(err_count), 32'd0);
        chk("bp_s_enc_count", 32'(s_enc_count), 32'd3);

        send_one("fifth", 7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345000, 32'h123452B7, 1'b0);
        chk("sat_enc_count", 32'(s_enc_count), 32'd3);
        chk("main_enc_count", 32'(enc_count), 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
